// File: rtl/deshift64_if.sv
// deshift64_if -- stream bundle for the 64-bit deserialiser.
//
// Input side : in_valid / in_wide / in_data offered by the producer,
//              in_ready returned by the deserialiser.
// Output side: out_valid / q presented by the deserialiser,
//              out_ready returned by the consumer.
//
// Modports:
//   master - the environment (drives chunks, drives out_ready)
//   slave  - the deserialiser itself
interface deshift64_if;
    logic        in_valid;
    logic        in_wide;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_ready;
    logic        out_valid;
    logic [63:0] q;

    modport master (
        output in_valid,
        output in_wide,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  q
    );

    modport slave (
        input  in_valid,
        input  in_wide,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output q
    );
endinterface

// File: rtl/deshift64.sv
// deshift64 -- collects 1-bit or 8-bit chunks, MSB first, into 64-bit words.
//
// Ports:
//   clk    - sole clock, rising edge
//   reset  - synchronous active-high reset, clears all state
//   flush  - synchronous discard of the partially collected word
//   bus    - deshift64_if.slave: chunk input handshake and word output
//            handshake (in_valid/in_wide/in_data/in_ready,
//            out_valid/out_ready/q)
//   count  - bits currently held in the accumulator (0..64)
//   err    - sticky flag: an 8-bit chunk arrived with fewer than 8 free bits
//
// The accumulator is kept separate from the output register so a new word
// can be assembled while the previous one waits for the consumer. If a word
// completes while the output slot is still occupied, it is parked in the
// accumulator with count=64 (which also deasserts in_ready) until the slot
// frees up.
module deshift64 (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    deshift64_if.slave  bus,
    output logic [6:0]  count,
    output logic        err
);

    localparam logic [6:0] FULL = 7'd64;

    logic [63:0] acc_q,       acc_d;
    logic [6:0]  count_q,     count_d;
    logic [63:0] word_q,      word_d;
    logic        out_valid_q, out_valid_d;
    logic        err_q,       err_d;

    logic        in_ready;
    logic        accept;
    logic        slot_free;
    logic        drain;
    logic        misaligned;
    logic [63:0] shift_acc;
    logic [6:0]  shift_count;

    assign in_ready    = (count_q != FULL) && !flush;
    assign accept      = bus.in_valid && in_ready;
    assign slot_free   = !out_valid_q || bus.out_ready;
    assign drain       = out_valid_q && bus.out_ready;
    // A byte needs 8 free bits; more than 56 held means it would overflow.
    assign misaligned  = bus.in_wide && (count_q > 7'd56);
    assign shift_acc   = bus.in_wide ? {acc_q[55:0], bus.in_data}
                                     : {acc_q[62:0], bus.in_data[0]};
    assign shift_count = count_q + (bus.in_wide ? 7'd8 : 7'd1);

    always_comb begin
        acc_d       = acc_q;
        count_d     = count_q;
        word_d      = word_q;
        out_valid_d = out_valid_q;
        err_d       = err_q;

        // Consumer takes the word; a load below may re-set out_valid.
        if (drain) begin
            out_valid_d = 1'b0;
        end

        if (flush) begin
            acc_d   = '0;
            count_d = '0;
        end else if (count_q == FULL) begin
            // Parked complete word waiting for a free output slot.
            if (slot_free) begin
                word_d      = acc_q;
                out_valid_d = 1'b1;
                count_d     = '0;
            end
        end else if (accept) begin
            if (misaligned) begin
                err_d = 1'b1;
            end else begin
                acc_d = shift_acc;
                if (shift_count == FULL && slot_free) begin
                    word_d      = shift_acc;
                    out_valid_d = 1'b1;
                    count_d     = '0;
                end else begin
                    count_d = shift_count;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= '0;
            count_q     <= '0;
            word_q      <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            count_q     <= count_d;
            word_q      <= word_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.q         = word_q;
    assign count         = count_q;
    assign err           = err_q;

endmodule

// File: tb/tb_deshift64.sv
module tb_deshift64;

    logic       clk;
    logic       reset;
    logic       flush;
    logic [6:0] count;
    logic       err;

    deshift64_if bus ();

    deshift64 dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus.slave),
        .count (count),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    // Word scoreboard: every handshake seen at a falling edge is the transfer
    // that happens on the following rising edge.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL word_unexpected: got q=%h, no word expected", bus.q);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if (bus.q !== e) begin
                    bad++;
                    $display("FAIL word_data: got q=%h, expected %h", bus.q, e);
                end else begin
                    $display("word ok: q=%h", bus.q);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("check ok: %s = %h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic wide, input logic [7:0] data);
        bus.in_valid = 1'b1;
        bus.in_wide  = wide;
        bus.in_data  = data;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [63:0] w);
        for (int i = 0; i < 8; i++) begin
            send(1'b1, w[63 - 8*i -: 8]);
        end
    endtask

    localparam logic [63:0] W1 = 64'h1020_3040_5060_7080;
    localparam logic [63:0] W2 = 64'hF0E0_D0C0_B0A0_9080;
    localparam logic [63:0] W3 = 64'hDEAD_BEEF_CAFE_F00D;
    localparam logic [63:0] W4 = 64'h0123_4567_89AB_CDEF;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_wide   = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_count", count, 0);
        chk("rst_q", bus.q, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_in_ready", bus.in_ready, 1);

        // Single bits: 1 then 63 zeros
        exp_q.push_back(64'h8000_0000_0000_0000);
        send(1'b0, 8'h01);
        for (int i = 0; i < 63; i++) send(1'b0, 8'h00);
        chk("bits_out_valid", bus.out_valid, 1);
        chk("bits_q", bus.q, 64'h8000_0000_0000_0000);
        chk("bits_count", count, 0);

        // Bytes 0x01..0x08, out_valid pulses one cycle
        exp_q.push_back(64'h0102_0304_0506_0708);
        for (int i = 1; i <= 8; i++) send(1'b1, 8'(i));
        chk("bytes_out_valid", bus.out_valid, 1);
        chk("bytes_q", bus.q, 64'h0102_0304_0506_0708);
        tick();
        chk("bytes_pulse_end", bus.out_valid, 0);
        chk("bytes_q_kept", bus.q, 64'h0102_0304_0506_0708);

        // Misaligned byte is dropped, err sticks
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFF5);
        for (int i = 0; i < 60; i++) send(1'b0, 8'h01);
        chk("mis_count_pre", count, 60);
        send(1'b1, 8'hAA);
        chk("mis_err", err, 1);
        chk("mis_count", count, 60);
        send(1'b0, 8'h00);
        send(1'b0, 8'h01);
        send(1'b0, 8'h00);
        send(1'b0, 8'h01);
        chk("mis_q", bus.q, 64'hFFFF_FFFF_FFFF_FFF5);
        chk("mis_err_sticky", err, 1);
        tick();

        // Backpressure: two words while out_ready=0
        bus.out_ready = 1'b0;
        exp_q.push_back(W1);
        send_word(W1);
        chk("bp_first_valid", bus.out_valid, 1);
        exp_q.push_back(W2);
        send_word(W2);
        chk("bp_count_full", count, 64);
        chk("bp_in_ready", bus.in_ready, 0);
        chk("bp_q_first", bus.q, W1);
        tick();
        chk("bp_hold_count", count, 64);
        chk("bp_hold_q", bus.q, W1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("bp_q_second", bus.q, W2);
        chk("bp_valid_second", bus.out_valid, 1);
        chk("bp_count_zero", count, 0);
        chk("bp_in_ready_back", bus.in_ready, 1);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_drained", bus.out_valid, 0);

        // Flush collision with a held output word
        bus.out_ready = 1'b0;
        exp_q.push_back(W3);
        send_word(W3);
        send(1'b1, 8'h33);
        send(1'b1, 8'h44);
        chk("fl_count_pre", count, 16);
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_wide  = 1'b1;
        bus.in_data  = 8'h5A;
        #1;
        chk("fl_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        chk("fl_count", count, 0);
        chk("fl_out_valid", bus.out_valid, 1);
        chk("fl_q", bus.q, W3);
        chk("fl_err", err, 1);
        bus.out_ready = 1'b1;
        tick();
        // Flushed bytes must not leak into the next word
        exp_q.push_back(W4);
        send_word(W4);
        chk("fl_next_q", bus.q, W4);
        tick();

        // Reset mid-word
        send(1'b1, 8'hC1);
        send(1'b1, 8'hC2);
        send(1'b1, 8'hC3);
        chk("rm_count_pre", count, 24);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rm_count", count, 0);
        chk("rm_q", bus.q, 0);
        chk("rm_out_valid", bus.out_valid, 0);
        chk("rm_err", err, 0);
        exp_q.push_back(64'h1122_3344_5566_7788);
        send_word(64'h1122_3344_5566_7788);
        chk("rm_q_new", bus.q, 64'h1122_3344_5566_7788);
        tick();
        tick();

        chk("scoreboard_empty", 64'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
